tracer_rx_channel: RTL and testbench

TRACER_RX_CHANNEL -- requirements
Module: tracer_rx_channel

---
 rtl/tracer_rx_channel.sv | 187 ++++++++++++++++++
 tb/tb_tracer_rx_channel.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tracer_rx_channel.sv
// Trace receive channel: writes a valid/ready trace stream into L2 under a programmed window.
// One write per accepted beat; the stream is stalled while an L2 request waits for grant.
module tracer_rx_channel #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_size_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic                      cfg_continuous_i,
  input  logic                      cfg_en_i,
  input  logic                      cfg_clr_i,
  output logic                      cfg_en_o,
  output logic                      cfg_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] cfg_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     cfg_bytes_left_o,
  input  logic [31:0]               data_i,
  input  logic                      data_valid_i,
  output logic                      data_ready_o,
  output logic                      l2_req_o,
  input  logic                      l2_gnt_i,
  output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
  output logic [31:0]               l2_wdata_o,
  output logic [3:0]                l2_be_o,
  output logic                      done_evt_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, REQ} state_t;

  state_t state_q, state_d;

  logic [L2_AWIDTH_NOAL-1:0] curr_addr_q, shd_start_q, pend_start_q, l2_addr_q;
  logic [TRANS_SIZE-1:0]     bytes_left_q, shd_size_q, pend_size_q;
  logic [1:0]                dsize_q, pend_dsize_q;
  logic                      cont_q, pend_cont_q, pend_q, done_q;
  logic [31:0]               l2_wdata_q;
  logic [3:0]                l2_be_q;

  logic [2:0]                step;
  logic [L2_AWIDTH_NOAL-1:0] step_a;
  logic [TRANS_SIZE-1:0]     step_t;
  logic                      accept, grant, last, complete;
  logic                      en_start, en_queue, take_pend;
  logic [L2_AWIDTH_NOAL-1:0] nxt_start;
  logic [TRANS_SIZE-1:0]     nxt_size;
  logic [1:0]                nxt_dsize;
  logic                      nxt_cont;
  logic [31:0]               wdata_fmt;
  logic [3:0]                be_fmt;

  always_comb begin
    step = 3'd1;
    if (dsize_q[1])      step = 3'd4;
    else if (dsize_q[0]) step = 3'd2;
  end

  assign step_a = {{(L2_AWIDTH_NOAL-3){1'b0}}, step};
  assign step_t = {{(TRANS_SIZE-3){1'b0}}, step};

  assign accept    = (state_q == ACTIVE) && data_valid_i && !cfg_clr_i;
  assign grant     = (state_q == REQ) && l2_gnt_i;
  assign last      = (bytes_left_q <= step_t);
  assign complete  = grant && last && !cfg_clr_i;
  assign en_start  = (state_q == IDLE) && cfg_en_i && (cfg_size_i != '0) && !cfg_clr_i;
  assign en_queue  = (state_q != IDLE) && cfg_en_i && !pend_q && !cfg_clr_i;
  // An enable landing in the completion cycle is consumed immediately as the next config.
  assign take_pend = complete && (pend_q || en_queue);

  assign nxt_start = pend_q ? pend_start_q : cfg_startaddr_i;
  assign nxt_size  = pend_q ? pend_size_q  : cfg_size_i;
  assign nxt_dsize = pend_q ? pend_dsize_q : cfg_datasize_i;
  assign nxt_cont  = pend_q ? pend_cont_q  : cfg_continuous_i;

  always_comb begin
    wdata_fmt = data_i;
    be_fmt    = 4'b1111;
    if (!dsize_q[1]) begin
      if (dsize_q[0]) begin
        wdata_fmt = {2{data_i[15:0]}};
        be_fmt    = curr_addr_q[1] ? 4'b1100 : 4'b0011;
      end else begin
        wdata_fmt = {4{data_i[7:0]}};
        be_fmt    = 4'b0001 << curr_addr_q[1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cfg_clr_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (en_start) state_d = ACTIVE;
        ACTIVE:  if (accept) state_d = REQ;
        REQ: begin
          if (grant) begin
            if (complete && !take_pend && !cont_q) state_d = IDLE;
            else                                   state_d = ACTIVE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      curr_addr_q  <= '0;
      bytes_left_q <= '0;
      dsize_q      <= '0;
      cont_q       <= 1'b0;
      shd_start_q  <= '0;
      shd_size_q   <= '0;
      pend_q       <= 1'b0;
      pend_start_q <= '0;
      pend_size_q  <= '0;
      pend_dsize_q <= '0;
      pend_cont_q  <= 1'b0;
      l2_addr_q    <= '0;
      l2_wdata_q   <= '0;
      l2_be_q      <= '0;
      done_q       <= 1'b0;
    end else if (cfg_clr_i) begin
      pend_q       <= 1'b0;
      bytes_left_q <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= complete;
      if (en_start) begin
        curr_addr_q  <= cfg_startaddr_i;
        bytes_left_q <= cfg_size_i;
        dsize_q      <= cfg_datasize_i;
        cont_q       <= cfg_continuous_i;
        shd_start_q  <= cfg_startaddr_i;
        shd_size_q   <= cfg_size_i;
      end
      if (en_queue && !complete) begin
        pend_q       <= 1'b1;
        pend_start_q <= cfg_startaddr_i;
        pend_size_q  <= cfg_size_i;
        pend_dsize_q <= cfg_datasize_i;
        pend_cont_q  <= cfg_continuous_i;
      end
      if (accept) begin
        l2_addr_q  <= curr_addr_q;
        l2_wdata_q <= wdata_fmt;
        l2_be_q    <= be_fmt;
      end
      if (grant) begin
        curr_addr_q  <= curr_addr_q + step_a;
        bytes_left_q <= last ? '0 : bytes_left_q - step_t;
        if (take_pend) begin
          curr_addr_q  <= nxt_start;
          bytes_left_q <= nxt_size;
          dsize_q      <= nxt_dsize;
          cont_q       <= nxt_cont;
          shd_start_q  <= nxt_start;
          shd_size_q   <= nxt_size;
          pend_q       <= 1'b0;
        end else if (complete && cont_q) begin
          curr_addr_q  <= shd_start_q;
          bytes_left_q <= shd_size_q;
        end
      end
    end
  end

  assign cfg_en_o         = (state_q != IDLE);
  assign cfg_pending_o    = pend_q;
  assign cfg_curr_addr_o  = curr_addr_q;
  assign cfg_bytes_left_o = bytes_left_q;
  assign data_ready_o     = (state_q == ACTIVE);
  assign l2_req_o         = (state_q == REQ);
  assign l2_addr_o        = l2_addr_q;
  assign l2_wdata_o       = l2_wdata_q;
  assign l2_be_o          = l2_be_q;
  assign done_evt_o       = done_q;

endmodule

// File: tb/tb_tracer_rx_channel.sv
// Directed bench for tracer_rx_channel; expected L2 writes queued at stimulus, checked on grant.
module tb_tracer_rx_channel;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [11:0] cfg_startaddr = '0;
  logic [15:0] cfg_size = '0;
  logic [1:0]  cfg_datasize = '0;
  logic        cfg_continuous = 1'b0;
  logic        cfg_en = 1'b0;
  logic        cfg_clr = 1'b0;
  logic        cfg_en_o, cfg_pending;
  logic [11:0] cfg_curr_addr;
  logic [15:0] cfg_bytes_left;
  logic [31:0] data = '0;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        l2_req;
  logic        l2_gnt = 1'b0;
  logic [11:0] l2_addr;
  logic [31:0] l2_wdata;
  logic [3:0]  l2_be;
  logic        done_evt;

  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  always #5 clk = ~clk;

  tracer_rx_channel #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cfg_startaddr_i(cfg_startaddr), .cfg_size_i(cfg_size),
    .cfg_datasize_i(cfg_datasize), .cfg_continuous_i(cfg_continuous),
    .cfg_en_i(cfg_en), .cfg_clr_i(cfg_clr),
    .cfg_en_o(cfg_en_o), .cfg_pending_o(cfg_pending),
    .cfg_curr_addr_o(cfg_curr_addr), .cfg_bytes_left_o(cfg_bytes_left),
    .data_i(data), .data_valid_i(data_valid), .data_ready_o(data_ready),
    .l2_req_o(l2_req), .l2_gnt_i(l2_gnt), .l2_addr_o(l2_addr),
    .l2_wdata_o(l2_wdata), .l2_be_o(l2_be), .done_evt_o(done_evt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic program_cfg(input logic [11:0] start, input logic [15:0] size,
                             input logic [1:0] ds, input logic cont);
    @(negedge clk);
    cfg_startaddr = start; cfg_size = size; cfg_datasize = ds; cfg_continuous = cont;
    cfg_en = 1'b1;
    @(negedge clk);
    cfg_en = 1'b0;
  endtask

  // Push one beat, hold off grant for gdelay cycles, check the write against the queue.
  task automatic beat(input logic [31:0] d, input int gdelay, input logic exp_done);
    int  n;
    wr_t e;
    @(negedge clk);
    data = d; data_valid = 1'b1;
    n = 0;
    while (!data_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready_timeout", data_ready, 1'b1);
    @(negedge clk);
    data_valid = 1'b0;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 1'b1, 1'b0);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    for (int i = 0; i <= gdelay; i++) begin
      if (i > 0) @(negedge clk);
      chk("l2_req", l2_req, 1'b1);
      chk("l2_addr", l2_addr, e.addr);
      chk("l2_wdata", l2_wdata, e.wdata);
      chk("l2_be", l2_be, e.be);
      chk("ready_in_req", data_ready, 1'b0);
    end
    l2_gnt = 1'b1;
    @(negedge clk);
    l2_gnt = 1'b0;
    chk("done_evt", done_evt, exp_done);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_en", cfg_en_o, 1'b0);
    chk("rst_req", l2_req, 1'b0);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_bytes", cfg_bytes_left, 16'h0);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_req_before_en", l2_req, 1'b0);

    // Size zero is ignored
    program_cfg(12'h100, 16'd0, 2'b10, 1'b0);
    chk("size0_ignored", cfg_en_o, 1'b0);

    // Word mode
    program_cfg(12'h100, 16'd8, 2'b10, 1'b0);
    chk("word_en", cfg_en_o, 1'b1);
    chk("word_bytes0", cfg_bytes_left, 16'd8);
    exp_q.push_back('{12'h100, 32'hDEADBEEF, 4'b1111});
    exp_q.push_back('{12'h104, 32'h01234567, 4'b1111});
    beat(32'hDEADBEEF, 0, 1'b0);
    chk("word_bytes1", cfg_bytes_left, 16'd4);
    beat(32'h01234567, 0, 1'b1);
    chk("word_bytes2", cfg_bytes_left, 16'd0);
    chk("word_idle", cfg_en_o, 1'b0);
    chk("word_addr_final", cfg_curr_addr, 12'h108);
    @(negedge clk);
    chk("word_done_once", done_evt, 1'b0);

    // Byte mode
    program_cfg(12'h003, 16'd2, 2'b00, 1'b0);
    exp_q.push_back('{12'h003, 32'hA5A5A5A5, 4'b1000});
    exp_q.push_back('{12'h004, 32'h5A5A5A5A, 4'b0001});
    beat(32'h000000A5, 0, 1'b0);
    beat(32'h0000005A, 0, 1'b1);
    chk("byte_idle", cfg_en_o, 1'b0);

    // Delayed grant
    program_cfg(12'h040, 16'd4, 2'b10, 1'b0);
    exp_q.push_back('{12'h040, 32'hCAFEF00D, 4'b1111});
    beat(32'hCAFEF00D, 3, 1'b1);

    // Continuous with a queued second config
    program_cfg(12'h180, 16'd4, 2'b10, 1'b1);
    program_cfg(12'h200, 16'd4, 2'b10, 1'b1);
    chk("pend_set", cfg_pending, 1'b1);
    exp_q.push_back('{12'h180, 32'h11111111, 4'b1111});
    beat(32'h11111111, 1, 1'b1);
    chk("pend_clr", cfg_pending, 1'b0);
    chk("pend_addr", cfg_curr_addr, 12'h200);
    chk("pend_active", cfg_en_o, 1'b1);
    exp_q.push_back('{12'h200, 32'h22222222, 4'b1111});
    beat(32'h22222222, 0, 1'b1);
    chk("cont_reload_addr", cfg_curr_addr, 12'h200);
    chk("cont_reload_bytes", cfg_bytes_left, 16'd4);
    chk("cont_active", cfg_en_o, 1'b1);

    // Clear while a request is outstanding, with an enable in the same cycle
    @(negedge clk);
    data = 32'h33333333; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("clr_pre_req", l2_req, 1'b1);
    cfg_clr = 1'b1; cfg_en = 1'b1;
    cfg_startaddr = 12'h400; cfg_size = 16'd4;
    @(negedge clk);
    cfg_clr = 1'b0; cfg_en = 1'b0;
    chk("clr_req", l2_req, 1'b0);
    chk("clr_idle", cfg_en_o, 1'b0);
    chk("clr_pend", cfg_pending, 1'b0);
    chk("clr_bytes", cfg_bytes_left, 16'd0);
    chk("clr_no_done", done_evt, 1'b0);
    @(negedge clk);
    chk("clr_no_done2", done_evt, 1'b0);
    chk("clr_en_ignored", cfg_en_o, 1'b0);

    // Half mode with address wrap
    program_cfg(12'hFFE, 16'd5, 2'b01, 1'b0);
    chk("half_bytes0", cfg_bytes_left, 16'd5);
    exp_q.push_back('{12'hFFE, 32'h12341234, 4'b1100});
    exp_q.push_back('{12'h000, 32'h56785678, 4'b0011});
    exp_q.push_back('{12'h002, 32'h9ABC9ABC, 4'b1100});
    beat(32'hAAAA1234, 0, 1'b0);
    chk("half_bytes1", cfg_bytes_left, 16'd3);
    beat(32'hBBBB5678, 2, 1'b0);
    chk("half_bytes2", cfg_bytes_left, 16'd1);
    beat(32'hCCCC9ABC, 0, 1'b1);
    chk("half_bytes3", cfg_bytes_left, 16'd0);
    chk("half_idle", cfg_en_o, 1'b0);
    chk("half_addr_final", cfg_curr_addr, 12'h004);

    // Asynchronous reset mid-request
    program_cfg(12'h500, 16'd4, 2'b10, 1'b0);
    @(negedge clk);
    data = 32'h44444444; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("arst_pre_req", l2_req, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_req", l2_req, 1'b0);
    chk("arst_en", cfg_en_o, 1'b0);
    chk("arst_addr", cfg_curr_addr, 12'h000);
    chk("arst_l2addr", l2_addr, 12'h000);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("arst_no_req", l2_req, 1'b0);
    end
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
